// File: rtl/dpsram_port_arb_if.sv
// Requester-side bus of the SRAM port arbiter: per-requester request fields
// packed side by side, plus the shared grant/read-return signals.
interface dpsram_port_arb_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 10
) ();
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dpsram_port_arb.sv
// Round-robin arbiter sharing one synchronous SRAM port between NREQ requesters,
// with bounded lock bursts and one-cycle registered read return.
//
// state  | meaning
// IDLE   | no burst in progress; round-robin scan from ptr each cycle
// LOCKED | owner holds the port for up to MAXLOCK consecutive grants
module dpsram_port_arb #(
  parameter int NREQ    = 3,
  parameter int DW      = 32,
  parameter int AW      = 10,
  parameter int MAXLOCK = 4
) (
  input  logic                clk,
  input  logic                n_reset,
  dpsram_port_arb_if.slave    bus,
  output logic                n_cs,
  output logic                n_we,
  output logic                n_oe,
  output logic [AW-1:0]       ad,
  output logic [DW-1:0]       di,
  input  logic [DW-1:0]       ram_do
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]    MAXLOCK_C = 4'(MAXLOCK);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [3:0]      lock_cnt, lock_cnt_nxt;
  logic [NREQ-1:0] gnt_c;
  logic [NREQ-1:0] rvalid_q;
  logic [NREQ-1:0] skip;
  logic            do_arb;
  logic            found;
  logic [PW-1:0]   win;
  int unsigned     idx;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      lock_cnt <= '0;
      rvalid_q <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      lock_cnt <= lock_cnt_nxt;
      rvalid_q <= gnt_c & ~bus.we;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    gnt_c        = '0;
    skip         = '0;
    do_arb       = 1'b0;
    found        = 1'b0;
    win          = '0;
    idx          = 0;

    if (state == LOCKED) begin
      if (bus.req[owner] && bus.lock[owner] && (lock_cnt < MAXLOCK_C)) begin
        gnt_c[owner] = 1'b1;
        lock_cnt_nxt = lock_cnt + 4'd1;
      end else begin
        do_arb       = 1'b1;
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
        // Burst exhausted: give everyone else a turn before the owner.
        if (bus.req[owner] && bus.lock[owner]) begin
          skip[owner] = 1'b1;
        end
      end
    end else begin
      do_arb = 1'b1;
    end

    if (do_arb) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) begin
          idx = idx - NREQ;
        end
        if (!found && bus.req[idx] && !skip[idx]) begin
          found = 1'b1;
          win   = PW'(idx);
        end
      end
      // Owner was the only requester: it starts a fresh burst.
      if (!found && (|skip)) begin
        found = 1'b1;
        win   = owner;
      end
      if (found) begin
        gnt_c[win] = 1'b1;
        ptr_nxt    = (win == LAST_IDX) ? '0 : win + PW'(1);
        if (bus.lock[win] && (MAXLOCK > 1)) begin
          state_nxt    = LOCKED;
          owner_nxt    = win;
          lock_cnt_nxt = 4'd1;
        end
      end
    end

    if (!n_reset) begin
      gnt_c = '0;
    end
  end

  always_comb begin
    n_cs = 1'b1;
    n_we = 1'b1;
    n_oe = 1'b1;
    ad   = '0;
    di   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) begin
        n_cs = 1'b0;
        n_we = ~bus.we[i];
        n_oe = 1'b0;
        ad   = bus.addr[i*AW +: AW];
        di   = bus.wdata[i*DW +: DW];
      end
    end
  end

  assign bus.gnt    = gnt_c;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = ram_do;

endmodule

// File: doc/dpsram_port_arb.md
Name: dpsram_port_arb

Overview:
- Round-robin arbiter that shares one port of the generic synchronous dual-port SRAM between NREQ requesters.
- Each requester uses a req/gnt handshake.
- The arbiter drives the SRAM port's n_cs/n_we/n_oe/ad/di signals and returns read data with a one-hot rvalid.
- An optional per-requester lock gives short atomic bursts, bounded by MAXLOCK to prevent starvation.
- Instantiated once per SRAM port that has more than one master.

Parameters:
- NREQ, 3, number of requesters (2..8).
- DW, 32, data width; matches the SRAM DW.
- AW, 10, address width; matches the SRAM AW.
- MAXLOCK, 4, maximum consecutive grants to one requester while it holds lock (1..15).

Ports:
- clk  input  1  posedge clock; the SRAM port clock uses the same net.
- n_reset  input  1  synchronous, active-low reset.
- req  input  NREQ  access request, one bit per requester.
- lock  input  NREQ  hold grant for the following cycle; only meaningful together with req.
- we  input  NREQ  1=write, 0=read, per requester.
- addr  input  NREQ*AW  per-requester address; requester i occupies bits [i*AW +: AW].
- wdata  input  NREQ*DW  per-requester write data; requester i occupies bits [i*DW +: DW].
- gnt  output  NREQ  one-hot grant; the access is accepted in the cycle gnt is high.
- rvalid  output  NREQ  one-hot, registered; read data is valid for that requester this cycle.
- rdata  output  DW  read data, shared by all requesters.
- n_cs  output  1  SRAM port select, active low.
- n_we  output  1  SRAM port write enable, active low.
- n_oe  output  1  SRAM port output enable, active low.
- ad  output  AW  SRAM port address.
- di  output  DW  SRAM port write data.
- ram_do  input  DW  SRAM port data out.

Behaviour:
- Reset (n_reset low at a posedge):
  - state=IDLE, pointer ptr=0, lock_cnt=0, rvalid=0.
  - While n_reset is low, gnt=0, n_cs=1, n_we=1, n_oe=1 and ad/di=0 (combinational gating), so no SRAM access occurs in a reset cycle.
  - A reset mid-burst drops the lock and discards any pending rvalid.
- Grant is combinational from req, state, ptr and owner. Exactly one gnt bit or none is active per cycle. Grant is never issued without req.
- IDLE arbitration:
  - Scan req starting at index ptr, wrapping modulo NREQ; the first set bit wins.
  - On a grant to winner w, ptr <= (w+1) mod NREQ.
  - If lock[w] is also set and MAXLOCK>1: state <= LOCKED, owner <= w, lock_cnt <= 1.
- LOCKED:
  - If req[owner] && lock[owner] && lock_cnt < MAXLOCK: gnt[owner]=1, lock_cnt++, ptr is unchanged.
  - If req[owner] && lock[owner] && lock_cnt == MAXLOCK: forced release. Arbitrate as IDLE this cycle but skip owner. If the owner is the only requester, it is granted as a new, fresh burst with lock_cnt=1.
  - Otherwise (owner drops req or lock): release and arbitrate as IDLE in the same cycle, so there is no bubble.
  - Other requesters' req bits are ignored while the owner holds the grant.
- SRAM drive while gnt[i]=1:
  - n_cs=0, n_we=~we[i], ad=addr[i], di=wdata[i], n_oe=0.
  - With no grant: n_cs=1, n_we=1, ad and di hold the value 0.
- Read latency:
  - A read granted in cycle N is sampled by the SRAM at the end of N.
  - rvalid[i]=1 in cycle N+1, with rdata=ram_do (combinational pass-through).
  - Back-to-back reads give one rvalid per cycle.
- Writes never raise rvalid. The SRAM's write-through value on ram_do is ignored.
- rdata is undefined whenever rvalid=0; the bench must not check it then.
- Throughput: one access per clock, with no idle cycle between different requesters.
- Same-address read after write, same port: the read in cycle N+1 returns the data written in cycle N.
- Conflicts with the other SRAM port are out of scope and are the system's responsibility.

Test Plan:
- Reset then idle: n_reset=0 for 2 cycles with req=3'b111 -> gnt=0, n_cs=1, rvalid=0. After release, the first grant is to requester 0.
- Round-robin: req=3'b111 held, no lock, all reads -> gnt sequence 001,010,100,001. The rvalid sequence matches, delayed by 1 cycle. ad follows addr of the granted requester.
- Write then read: requester 1 writes 0xDEADBEEF to 0x155, then reads 0x155 -> rvalid=010 one cycle after the read grant, rdata=0xDEADBEEF.
- Lock limit: requester 2 holds req+lock, requester 0 holds req, MAXLOCK=4 -> gnt=100 for 4 cycles, then 001, then 100.
- Lock dropped early: requester 0 locks for 2 grants then deasserts lock, with requester 1 requesting -> gnt=010 in the next cycle, with no idle cycle.
- Reset mid-burst: assert n_reset low during a LOCKED read burst -> rvalid=0 in the following cycle. ptr resets to 0 and the next grant goes to the lowest requesting index.
